receiver_calc: RTL and testbench
================================

// Module: receiver_calc
// PURPOSE
//  UART receive path of the calculator frame; mirror of the calculator transmitter on the Arty A7-35T.
//  Deserialises 8N1 ASCII characters from rxd_pin and packs them, first character in the MSBs, into an M-bit message word.
//  Publishes a one-cycle msg_valid when a carriage return arrives or when M/N characters are held.
//  Feeds the calculator core; the transmitter sends the result back.
// PARAMETERS
//  N            8      data bits per character (one ASCII byte)
//  M            128    message width in bits (M/N = 16 characters max)
//  CLKS_PER_BIT 10417  clk cycles per bit (100 MHz / 9600 baud); the bench uses 16
// PORTS
//  clk        in   1        system clock, 100 MHz; single clock domain
//  reset      in   1        asynchronous, active-high reset
//  rxd_pin    in   1        UART serial input, idle high, asynchronous to clk
//  msg        out  M        last complete message; char0 in msg[M-1:M-N]; unused low bytes 8'h00
//  msg_len    out  5        number of characters in msg (1..M/N)
//  msg_valid  out  1        one-cycle pulse; msg/msg_len are updated in the same cycle
//  frame_err  out  1        one-cycle pulse on a bad stop bit
//  led        out  4        [0] receiving, [1] sticky frame error, [2] toggles per message, [3] buffer non-empty
// BEHAVIOUR
//  Reset (async, active-high): all outputs 0; FSM=IDLE; buffer cleared; char count 0; synchroniser flops set to 1.
//  rxd_pin passes through a 2-FF synchroniser (rx_s) before any use.
//  Byte FSM (baud counter bc, bit index bi):
//   IDLE : rx_s==0 -> START, bc=0.
//   START: at bc==CLKS_PER_BIT/2-1, sample. 0 -> DATA, bc=0, bi=0. 1 -> IDLE (glitch rejected, nothing recorded).
//   DATA : at bc==CLKS_PER_BIT-1, shift in rx_s LSB-first, bi++. After the Nth bit -> STOP.
//   STOP : at bc==CLKS_PER_BIT-1, sample.
//          1 -> byte_rdy pulse, then IDLE.
//          0 -> frame_err pulse, led[1]=1, byte discarded; WAIT_HI until rx_s==1, then IDLE.
//  Message assembly on byte_rdy (byte b, count c):
//   b==8'h0D with c>0: msg<=buffer, msg_len<=c, msg_valid=1, led[2] toggles, buffer and c cleared.
//   b==8'h0D with c==0: ignored; no pulse.
//   otherwise: buffer[M-1-N*c -: N]<=b, c++.
//   If c reaches M/N: publish in the same cycle as the store, exactly as for CR.
//   A following CR is then the empty case and is ignored.
//  Latency: msg_valid rises 1 clk after the stop-bit sample of the terminating byte. No back-pressure; msg holds until the next msg_valid.
//  Characters arriving after msg_valid go to the cleared buffer and do not disturb msg.
//  8'h0A (LF) and all other bytes are stored as data.
//  Sampling is fixed at the mid-bit point; no majority vote.
//  Reset mid-character or mid-message: partial byte and buffer are lost; msg is cleared to 0.
//  led[0]=1 in any state other than IDLE. led[3]=(c!=0).
// STRUCTURE
//  Shared package/include calc_defs.vh:
//   ASCII_CR=8'h0D; default CLKS_PER_BIT; FSM state encodings IDLE/START/DATA/STOP/WAIT_HI.
//   The transmitter uses the same CLKS_PER_BIT and N.
//  Sub-module uart_rx_byte (clk, reset, rx_s -> byte[N-1:0], byte_rdy, frame_err) holds the byte FSM.
//  receiver_calc holds the synchroniser, the message buffer/counter and the LED logic.
// TESTING (CLKS_PER_BIT=16, bit period 160 ns)
//  Reset asserted at t=0 -> msg=0, msg_valid=0, led=4'b0000; rxd_pin held 1 for 50 clk -> no activity, led[0]=0.
//  Send "12+3" then 8'h0D ->
//   one msg_valid pulse; msg_len=4; msg[127:96]=32'h31322B33; msg[95:0]=0; led[2]=1.
//  Send 16 chars "0123456789ABCDEF" with no CR ->
//   msg_valid after the 16th stop bit; msg=ASCII string, char '0' in msg[127:120]; msg_len=16.
//   A following CR gives no pulse.
//  Low glitch of 4 clk on an idle line -> no byte; led[0] returns to 0 within 9 clk.
//  Byte 8'h35 sent with stop bit 0 -> frame_err pulse, led[1]=1 sticky, c unchanged.
//   Then "7" + CR -> msg_len=1, msg[127:120]=8'h37.
//  Reset pulsed during the 3rd char of "456" -> outputs 0.
//   Then "9" + CR -> msg_len=1, msg[127:120]=8'h39.
//  Back-to-back bytes (next start bit immediately after stop) ->
//   all received; "1+1" CR gives msg[127:104]=24'h312B31.

Source files
------------

// File: rtl/receiver_calc_pkg.sv
// Shared definitions for the calculator UART receive path: defaults, ASCII codes, byte FSM states.
package receiver_calc_pkg;

    localparam int unsigned N_DEF            = 8;      // data bits per character
    localparam int unsigned M_DEF            = 128;    // message width in bits
    localparam int unsigned CLKS_PER_BIT_DEF = 10417;  // 100 MHz / 9600 baud
    localparam int unsigned LEN_W            = 5;      // width of msg_len

    localparam logic [7:0] ASCII_CR = 8'h0D;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_WAIT_HI
    } rx_state_t;

endpackage

// File: rtl/receiver_calc_if.sv
// Receiver bus: serial input plus the published message and status outputs.
//  rxd_pin   : UART serial input (idle high)
//  msg       : last complete message, char0 in the MSBs
//  msg_len   : characters in msg
//  msg_valid : one-cycle pulse when msg/msg_len update
//  frame_err : one-cycle pulse on a bad stop bit
//  led       : [0] receiving, [1] sticky frame error, [2] message toggle, [3] buffer non-empty
interface receiver_calc_if
    import receiver_calc_pkg::*;
#(
    parameter int unsigned M = M_DEF
);
    logic             rxd_pin;
    logic [M-1:0]     msg;
    logic [LEN_W-1:0] msg_len;
    logic             msg_valid;
    logic             frame_err;
    logic [3:0]       led;

    modport master (
        input  rxd_pin,
        output msg, msg_len, msg_valid, frame_err, led
    );

    modport slave (
        output rxd_pin,
        input  msg, msg_len, msg_valid, frame_err, led
    );
endinterface

// File: rtl/receiver_calc_uart_rx_byte.sv
// 8N1 byte deserialiser with mid-bit sampling.
//  clk, reset   : clock, async active-high reset
//  rx_s         : synchronised serial input
//  data_byte    : assembled byte, valid while byte_rdy_c is high
//  byte_rdy_c   : high in the cycle the good stop bit is sampled
//  frame_err_c  : high in the cycle a bad stop bit is sampled
//  busy_c       : FSM is outside IDLE
module receiver_calc_uart_rx_byte
    import receiver_calc_pkg::*;
#(
    parameter int unsigned N            = N_DEF,
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         rx_s,
    output logic [N-1:0] data_byte,
    output logic         byte_rdy_c,
    output logic         frame_err_c,
    output logic         busy_c
);
    localparam int unsigned BC_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned BI_W = $clog2(N);
    localparam int unsigned HALF = CLKS_PER_BIT / 2;

    rx_state_t       state;
    logic [BC_W-1:0] bc;
    logic [BI_W-1:0] bi;
    logic [N-1:0]    shreg;
    logic            bit_end;

    assign bit_end     = (bc == BC_W'(CLKS_PER_BIT - 1));
    assign byte_rdy_c  = (state == ST_STOP) && bit_end && rx_s;
    assign frame_err_c = (state == ST_STOP) && bit_end && !rx_s;
    assign busy_c      = (state != ST_IDLE);
    assign data_byte   = shreg;

    // Byte FSM: start-bit validation at half period, then one sample per bit period
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            bc    <= '0;
            bi    <= '0;
            shreg <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state <= ST_START;
                        bc    <= '0;
                    end
                end
                ST_START: begin
                    if (bc == BC_W'(HALF - 1)) begin
                        bc <= '0;
                        bi <= '0;
                        state <= rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        bc <= bc + BC_W'(1);
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        bc    <= '0;
                        shreg <= {rx_s, shreg[N-1:1]};
                        if (bi == BI_W'(N - 1)) begin
                            state <= ST_STOP;
                        end else begin
                            bi <= bi + BI_W'(1);
                        end
                    end else begin
                        bc <= bc + BC_W'(1);
                    end
                end
                ST_STOP: begin
                    if (bit_end) begin
                        bc    <= '0;
                        state <= rx_s ? ST_IDLE : ST_WAIT_HI;
                    end else begin
                        bc <= bc + BC_W'(1);
                    end
                end
                ST_WAIT_HI: begin
                    if (rx_s) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/receiver_calc.sv
// UART receive path of the calculator: synchroniser, byte receiver, message assembly, LEDs.
//  clk, reset : clock, async active-high reset
//  bus        : receiver_calc_if master (rxd_pin in; msg, msg_len, msg_valid, frame_err, led out)
module receiver_calc
    import receiver_calc_pkg::*;
#(
    parameter int unsigned N            = N_DEF,
    parameter int unsigned M            = M_DEF,
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic            clk,
    input  logic            reset,
    receiver_calc_if.master bus
);
    localparam int unsigned CHARS = M / N;
    localparam int unsigned IDX_W = $clog2(M);

    logic             sync1, rx_s;
    logic [N-1:0]     data_byte;
    logic             byte_rdy_c, frame_err_c, busy_c;
    logic [M-1:0]     buffer, ins_buf;
    logic [LEN_W-1:0] cnt;
    logic [IDX_W-1:0] shamt;
    logic             toggle, sticky;

    // Two-flop synchroniser, reset to the idle line level
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= bus.rxd_pin;
            rx_s  <= sync1;
        end
    end

    receiver_calc_uart_rx_byte #(
        .N            (N),
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk         (clk),
        .reset       (reset),
        .rx_s        (rx_s),
        .data_byte   (data_byte),
        .byte_rdy_c  (byte_rdy_c),
        .frame_err_c (frame_err_c),
        .busy_c      (busy_c)
    );

    // Buffer with the incoming byte dropped into slot cnt (slot 0 in the MSBs)
    always_comb begin
        shamt   = IDX_W'(M - N) - IDX_W'(N) * IDX_W'(cnt);
        ins_buf = buffer | (M'(data_byte) << shamt);
    end

    // Message assembly: CR or a full buffer publishes; empty CR is ignored
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buffer        <= '0;
            cnt           <= '0;
            toggle        <= 1'b0;
            sticky        <= 1'b0;
            bus.msg       <= '0;
            bus.msg_len   <= '0;
            bus.msg_valid <= 1'b0;
            bus.frame_err <= 1'b0;
        end else begin
            bus.msg_valid <= 1'b0;
            bus.frame_err <= frame_err_c;
            if (frame_err_c) begin
                sticky <= 1'b1;
            end
            if (byte_rdy_c) begin
                if (data_byte == N'(ASCII_CR)) begin
                    if (cnt != '0) begin
                        bus.msg       <= buffer;
                        bus.msg_len   <= cnt;
                        bus.msg_valid <= 1'b1;
                        toggle        <= ~toggle;
                        buffer        <= '0;
                        cnt           <= '0;
                    end
                end else if (cnt == LEN_W'(CHARS - 1)) begin
                    bus.msg       <= ins_buf;
                    bus.msg_len   <= LEN_W'(CHARS);
                    bus.msg_valid <= 1'b1;
                    toggle        <= ~toggle;
                    buffer        <= '0;
                    cnt           <= '0;
                end else begin
                    buffer <= ins_buf;
                    cnt    <= cnt + LEN_W'(1);
                end
            end
        end
    end

    // Status LEDs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.led <= '0;
        end else begin
            bus.led <= {(cnt != '0), toggle, sticky, busy_c};
        end
    end
endmodule

// File: tb/tb_receiver_calc.sv
// Self-checking bench for receiver_calc with a message scoreboard.
module tb_receiver_calc;
    import receiver_calc_pkg::*;

    localparam int unsigned CPB = 16;

    typedef struct {
        logic [127:0] msg;
        logic [4:0]   len;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   valid_cnt = 0;
    int   ferr_cnt = 0;

    always #5 clk = ~clk;

    receiver_calc_if #(.M(128)) bif ();

    receiver_calc #(
        .N            (8),
        .M            (128),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    // Advance one clock, sampling at the falling edge and scoring any published message
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (!reset && bif.frame_err === 1'b1) ferr_cnt++;
        if (!reset && bif.msg_valid === 1'b1) begin
            valid_cnt++;
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_valid: got msg=%h len=%0d, expected no pulse", bif.msg, bif.msg_len);
            end else begin
                e = sb.pop_front();
                if (bif.msg !== e.msg) begin
                    bad++;
                    $display("FAIL msg: got %h expected %h", bif.msg, e.msg);
                end
                total++;
                if (bif.msg_len !== e.len) begin
                    bad++;
                    $display("FAIL msg_len: got %0d expected %0d", bif.msg_len, e.len);
                end
            end
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        bif.rxd_pin = 1'b0;
        ticks(CPB);
        for (int i = 0; i < 8; i++) begin
            bif.rxd_pin = b[i];
            ticks(CPB);
        end
        bif.rxd_pin = stop_bit;
        ticks(CPB);
        bif.rxd_pin = 1'b1;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
    endtask

    task automatic expect_msg(input string s);
        exp_t e;
        e.msg = '0;
        for (int i = 0; i < s.len(); i++) e.msg[127-8*i -: 8] = s[i];
        e.len = 5'(s.len());
        sb.push_back(e);
    endtask

    task automatic wait_drain(input string name, input int limit);
        for (int i = 0; i < limit && sb.size() != 0; i++) tick();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL %s timeout: %0d messages outstanding, expected 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bif.rxd_pin = 1'b1;
        ticks(3);
        total++;
        if (bif.msg !== 128'h0) begin bad++; $display("FAIL reset_msg: got %h expected 0", bif.msg); end
        total++;
        if (bif.msg_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b expected 0", bif.msg_valid); end
        total++;
        if (bif.led !== 4'b0000) begin bad++; $display("FAIL reset_led: got %b expected 0000", bif.led); end
        total++;
        if (bif.msg_len !== 5'd0) begin bad++; $display("FAIL reset_len: got %0d expected 0", bif.msg_len); end
        reset = 1'b0;
        ticks(50);
        total++;
        if (bif.led !== 4'b0000) begin bad++; $display("FAIL idle_led: got %b expected 0000", bif.led); end
        total++;
        if (valid_cnt != 0) begin bad++; $display("FAIL idle_valid: got %0d pulses expected 0", valid_cnt); end
    endtask

    task automatic test_cr_msg();
        int v0 = valid_cnt;
        expect_msg("12+3");
        send_str("12+3");
        send_byte(8'h0D, 1'b1);
        wait_drain("cr_msg", 200);
        ticks(4);
        total++;
        if (valid_cnt != v0 + 1) begin bad++; $display("FAIL cr_pulses: got %0d expected %0d", valid_cnt - v0, 1); end
        total++;
        if (bif.led[2] !== 1'b1) begin bad++; $display("FAIL cr_led2: got %b expected 1", bif.led[2]); end
        total++;
        if (bif.led[3] !== 1'b0) begin bad++; $display("FAIL cr_led3: got %b expected 0", bif.led[3]); end
    endtask

    task automatic test_full();
        int v0 = valid_cnt;
        expect_msg("0123456789ABCDEF");
        send_str("0123456789ABCDEF");
        wait_drain("full_msg", 50);
        send_byte(8'h0D, 1'b1);
        ticks(20);
        total++;
        if (valid_cnt != v0 + 1) begin bad++; $display("FAIL full_pulses: got %0d expected %0d", valid_cnt - v0, 1); end
        total++;
        if (bif.led[2] !== 1'b0) begin bad++; $display("FAIL full_led2: got %b expected 0", bif.led[2]); end
    endtask

    task automatic test_glitch();
        int v0 = valid_cnt;
        int f0 = ferr_cnt;
        bif.rxd_pin = 1'b0;
        ticks(4);
        bif.rxd_pin = 1'b1;
        total++;
        if (bif.led[0] !== 1'b1) begin bad++; $display("FAIL glitch_busy: got %b expected 1", bif.led[0]); end
        ticks(9);
        total++;
        if (bif.led[0] !== 1'b0) begin bad++; $display("FAIL glitch_led0: got %b expected 0", bif.led[0]); end
        total++;
        if (bif.led[3] !== 1'b0 || valid_cnt != v0 || ferr_cnt != f0) begin
            bad++;
            $display("FAIL glitch_side: led3=%b pulses=%0d ferr=%0d expected 0/0/0", bif.led[3], valid_cnt - v0, ferr_cnt - f0);
        end
    endtask

    task automatic test_frame_err();
        int f0 = ferr_cnt;
        send_byte(8'h35, 1'b0);
        ticks(6);
        total++;
        if (ferr_cnt != f0 + 1) begin bad++; $display("FAIL ferr_pulse: got %0d expected 1", ferr_cnt - f0); end
        total++;
        if (bif.led[1] !== 1'b1) begin bad++; $display("FAIL ferr_led1: got %b expected 1", bif.led[1]); end
        total++;
        if (bif.led[3] !== 1'b0) begin bad++; $display("FAIL ferr_count: led3 got %b expected 0", bif.led[3]); end
        expect_msg("7");
        send_str("7");
        send_byte(8'h0D, 1'b1);
        wait_drain("ferr_msg", 200);
        total++;
        if (bif.led[1] !== 1'b1) begin bad++; $display("FAIL ferr_sticky: got %b expected 1", bif.led[1]); end
    endtask

    task automatic test_reset_mid();
        string s6 = "6";
        logic [7:0] b;
        b = s6[0];
        send_str("45");
        ticks(2);
        total++;
        if (bif.led[3] !== 1'b1) begin bad++; $display("FAIL mid_led3: got %b expected 1", bif.led[3]); end
        bif.rxd_pin = 1'b0;
        ticks(CPB);
        for (int i = 0; i < 3; i++) begin
            bif.rxd_pin = b[i];
            ticks(CPB);
        end
        reset = 1'b1;
        ticks(2);
        bif.rxd_pin = 1'b1;
        total++;
        if (bif.msg !== 128'h0 || bif.msg_len !== 5'd0) begin
            bad++;
            $display("FAIL mid_reset_msg: got msg=%h len=%0d expected 0/0", bif.msg, bif.msg_len);
        end
        total++;
        if (bif.led !== 4'b0000) begin bad++; $display("FAIL mid_reset_led: got %b expected 0000", bif.led); end
        reset = 1'b0;
        ticks(5);
        expect_msg("9");
        send_str("9");
        send_byte(8'h0D, 1'b1);
        wait_drain("mid_msg", 200);
    endtask

    task automatic test_back_to_back();
        expect_msg("1+1");
        send_str("1+1");
        send_byte(8'h0D, 1'b1);
        wait_drain("b2b_msg", 200);
        total++;
        if (bif.msg[127:104] !== 24'h312B31) begin bad++; $display("FAIL b2b_top: got %h expected 312b31", bif.msg[127:104]); end
    endtask

    initial begin
        test_reset();
        test_cr_msg();
        test_full();
        test_glitch();
        test_frame_err();
        test_reset_mid();
        test_back_to_back();
        ticks(5);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
